thread_scheduler: RTL and testbench
===================================

Name: thread_scheduler

Overview:
- Round-robin barrel-thread scheduler in front of the per-thread PC array.
- Each cycle it picks one eligible hardware thread and drives that thread's index plus the PC increment flag into the PC array.
- Eligibility per thread = software enable bit AND per-thread stall countdown at zero. Later pipeline stages load the stall countdown on branch/load hazards.
- Global pipeline hold freezes issue.

Parameters:
THREAD_INDEX_BITS, 3, width of thread index; thread count N = 2**THREAD_INDEX_BITS
STALL_CNT_WIDTH, 4, width of per-thread stall countdown (max stall 2**STALL_CNT_WIDTH-1 cycles)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; one clock, reset sampled on posedge clk
in_thread_enable  input  N  per-thread enable mask, bit i = thread i may issue
in_stall_valid  input  1  load a stall countdown this cycle
in_stall_thread_index  input  THREAD_INDEX_BITS  thread whose countdown is loaded
in_stall_cycles  input  STALL_CNT_WIDTH  countdown load value
in_pipeline_hold  input  1  global freeze: no issue while high
out_thread_index  output  THREAD_INDEX_BITS  issued thread, to PC array index
out_thread_valid  output  1  out_thread_index is a real issue slot
out_increment_flag  output  1  to PC array increment input
out_idle  output  1  last decision found no eligible thread (hold not asserted)

Behaviour:
- Reset values:
  - all stall counters 0
  - last-grant pointer = N-1, so the first grant is thread 0
  - out_thread_index 0, out_thread_valid 0, out_increment_flag 0, out_idle 0
  - Reset overrides all inputs. Reset mid-operation discards in-flight stalls and restarts at thread 0.
- Eligibility, combinational from registered state:
  - elig[i] = in_thread_enable[i] & (cnt[i]==0)
  - A stall loaded this cycle does not affect this cycle's decision.
- Decision each cycle: search positions ptr+1, ptr+2, ..., ptr+N, modulo N (ptr itself is checked last). The first eligible thread is the grant.
- All outputs are registered; 1-cycle latency from decision to outputs.
- Grant found and hold low, at the next edge:
  - out_thread_index = grant
  - out_thread_valid = 1, out_increment_flag = 1, out_idle = 0
  - ptr = grant
- No eligible thread and hold low, at the next edge:
  - out_thread_valid = 0, out_increment_flag = 0, out_idle = 1
  - out_thread_index and ptr hold
- Hold high:
  - out_thread_valid = 0, out_increment_flag = 0, out_idle = 0
  - out_thread_index and ptr hold
  - No PC increment may occur while frozen.
- out_increment_flag always equals out_thread_valid. It is kept as a separate port for PC-array wiring.
- Stall counters:
  - Every cycle, cnt[i] decrements by 1 if nonzero. Decrement continues during hold and while the thread is disabled.
  - in_stall_valid loads cnt[in_stall_thread_index] = in_stall_cycles. The load overrides that thread's decrement in the same cycle; a re-stall overwrites a running count.
  - A load value of 0 clears the stall.
  - After a load of K, the thread is ineligible for exactly the K following decisions.
- Wrap-around: pointer and search arithmetic are modulo N; no saturation.
- Single eligible thread: it is granted every cycle.
- Enable bit dropped while a thread's issue is registered: the registered issue stands; the thread is excluded from the next decision onward.

Test Plan:
1. Reset 2 cycles, in_thread_enable=8'hFF, no hold/stall -> out_thread_index sequence 0,1,2,3,4,5,6,7,0,1 with valid=increment=1 every cycle from first post-reset edge.
2. in_thread_enable=8'b1010_0100 from reset -> sequence 2,5,7,2,5,7; out_idle stays 0.
3. All enabled; in cycle c (out_thread_index=3) assert stall thread 3, cycles 10 -> outputs from c+1: 4,5,6,7,0,1,2,4,5,6,7,0,1,2,3.
4. All enabled; hold high for 3 cycles after thread 5 issues -> valid=increment=0 for 3 cycles, index stays 5; after release, issue resumes at 6.
5. in_thread_enable=0 -> valid=0, out_idle=1, index holds; set bit 4 -> next output is 4 with valid=1, out_idle=0, then 4 repeated every cycle.
6. Stall thread 1 for 15 cycles, assert reset mid-count for one cycle -> all outputs 0 during reset, then sequence 0,1,2,... (thread 1 not skipped).

Source files
------------

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler
// Description : Round-robin barrel-thread scheduler that sits in front of the
//               per-thread PC array. Each cycle it picks one eligible hardware
//               thread and issues its index together with the PC increment
//               flag. A thread is eligible when its software enable bit is set
//               and its stall countdown has reached zero. Later pipeline
//               stages load the countdown on branch/load hazards. A global
//               pipeline hold freezes issue.
//
// Ports       :
//   clk                   - clock, all state updates on the rising edge
//   reset                 - synchronous, active-high reset
//   in_thread_enable      - per-thread enable mask (bit i = thread i may issue)
//   in_stall_valid        - load a stall countdown this cycle
//   in_stall_thread_index - thread whose countdown is loaded
//   in_stall_cycles       - countdown load value (0 clears the stall)
//   in_pipeline_hold      - global freeze, no issue while high
//   out_thread_index      - issued thread, to the PC array index
//   out_thread_valid      - out_thread_index is a real issue slot
//   out_increment_flag    - PC array increment (always equals valid)
//   out_idle              - last decision found no eligible thread
//
// Revision    : 1.0 - initial release
// ============================================================================
module thread_scheduler #(
    parameter int THREAD_INDEX_BITS = 3,
    parameter int STALL_CNT_WIDTH   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [(1<<THREAD_INDEX_BITS)-1:0]   in_thread_enable,
    input  logic                                in_stall_valid,
    input  logic [THREAD_INDEX_BITS-1:0]        in_stall_thread_index,
    input  logic [STALL_CNT_WIDTH-1:0]          in_stall_cycles,
    input  logic                                in_pipeline_hold,
    output logic [THREAD_INDEX_BITS-1:0]        out_thread_index,
    output logic                                out_thread_valid,
    output logic                                out_increment_flag,
    output logic                                out_idle
);

    localparam int c_NUM_THREADS = 1 << THREAD_INDEX_BITS;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [STALL_CNT_WIDTH-1:0]   r_cnt [c_NUM_THREADS];
    logic [THREAD_INDEX_BITS-1:0] r_ptr;
    logic [THREAD_INDEX_BITS-1:0] r_index;
    logic                         r_valid;
    logic                         r_idle;

    // ------------------------------------------------------------------------
    // Combinational decision signals
    // ------------------------------------------------------------------------
    logic [c_NUM_THREADS-1:0]     w_elig;
    logic                         w_found;
    logic [THREAD_INDEX_BITS-1:0] w_grant;
    logic [THREAD_INDEX_BITS-1:0] w_pos;

    // Eligibility uses only registered counter state, so a stall loaded in
    // the current cycle cannot influence the current decision.
    for (genvar gi = 0; gi < c_NUM_THREADS; gi++) begin : g_elig
        assign w_elig[gi] = in_thread_enable[gi] & (r_cnt[gi] == '0);
    end

    // Round-robin search starting just after the last grant. The offset is
    // truncated to the index width so the position wraps modulo N for free;
    // the final offset (N) lands back on r_ptr, which is therefore checked
    // last and lets a lone eligible thread be granted every cycle.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_pos   = r_ptr;
        for (int k = 1; k <= c_NUM_THREADS; k++) begin
            w_pos = r_ptr + THREAD_INDEX_BITS'(k);
            if (!w_found && w_elig[w_pos]) begin
                w_found = 1'b1;
                w_grant = w_pos;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stall countdowns
    // ------------------------------------------------------------------------
    // Counters run down regardless of hold or enable, so a hazard window is
    // measured in real cycles. A load takes priority over the decrement for
    // the addressed thread, which also makes a re-stall overwrite a running
    // count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NUM_THREADS; i++) begin
            if (reset) begin
                r_cnt[i] <= '0;
            end else if (in_stall_valid &&
                         (in_stall_thread_index == THREAD_INDEX_BITS'(i))) begin
                r_cnt[i] <= in_stall_cycles;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Issue registers
    // ------------------------------------------------------------------------
    // The pointer resets to N-1 so the first search begins at thread 0, while
    // the visible index resets to 0; that is why the pointer is kept apart
    // from the output index even though they match after the first grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '1;
            r_index <= '0;
            r_valid <= 1'b0;
            r_idle  <= 1'b0;
        end else if (in_pipeline_hold) begin
            // Frozen: no issue slot, not reported as idle, index and pointer
            // keep their values so issue resumes in order after release.
            r_valid <= 1'b0;
            r_idle  <= 1'b0;
        end else if (w_found) begin
            r_ptr   <= w_grant;
            r_index <= w_grant;
            r_valid <= 1'b1;
            r_idle  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_idle  <= 1'b1;
        end
    end

    assign out_thread_index   = r_index;
    assign out_thread_valid   = r_valid;
    // Separate port for PC-array wiring; an issue slot always increments.
    assign out_increment_flag = r_valid;
    assign out_idle           = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
module tb_thread_scheduler;

    localparam int TIB = 3;
    localparam int SCW = 4;
    localparam int N   = 1 << TIB;

    logic           clk;
    logic           reset;
    logic [N-1:0]   in_thread_enable;
    logic           in_stall_valid;
    logic [TIB-1:0] in_stall_thread_index;
    logic [SCW-1:0] in_stall_cycles;
    logic           in_pipeline_hold;
    logic [TIB-1:0] out_thread_index;
    logic           out_thread_valid;
    logic           out_increment_flag;
    logic           out_idle;

    thread_scheduler #(
        .THREAD_INDEX_BITS (TIB),
        .STALL_CNT_WIDTH   (SCW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_thread_enable      (in_thread_enable),
        .in_stall_valid        (in_stall_valid),
        .in_stall_thread_index (in_stall_thread_index),
        .in_stall_cycles       (in_stall_cycles),
        .in_pipeline_hold      (in_pipeline_hold),
        .out_thread_index      (out_thread_index),
        .out_thread_valid      (out_thread_valid),
        .out_increment_flag    (out_increment_flag),
        .out_idle              (out_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counters, last grant and expected outputs.
    int m_cnt [N];
    int m_ptr;
    int m_idx;
    int m_valid;
    int m_idle;

    typedef struct {
        logic           rst;
        logic [N-1:0]   en;
        logic           hold;
        logic [TIB-1:0] eidx;
        logic           evalid;
        logic           eidle;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock from the currently driven inputs, clock
    // the DUT, then compare all outputs against the model.
    task automatic tick();
        int found;
        int g;
        int t;
        if (reset) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr = N - 1; m_idx = 0; m_valid = 0; m_idle = 0;
        end else begin
            found = 0; g = 0;
            for (int k = 1; k <= N; k++) begin
                t = (m_ptr + k) % N;
                if (found == 0 && in_thread_enable[t] && m_cnt[t] == 0) begin
                    found = 1; g = t;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (in_stall_valid && int'(in_stall_thread_index) == i)
                    m_cnt[i] = int'(in_stall_cycles);
                else if (m_cnt[i] > 0)
                    m_cnt[i] = m_cnt[i] - 1;
            end
            if (in_pipeline_hold) begin
                m_valid = 0; m_idle = 0;
            end else if (found != 0) begin
                m_idx = g; m_ptr = g; m_valid = 1; m_idle = 0;
            end else begin
                m_valid = 0; m_idle = 1;
            end
        end
        @(posedge clk);
        #1;
        check("model_index", int'(out_thread_index), m_idx);
        check("model_valid", int'(out_thread_valid), m_valid);
        check("model_incr",  int'(out_increment_flag), m_valid);
        check("model_idle",  int'(out_idle), m_idle);
    endtask

    function automatic vec_t mk(input logic rst, input logic [N-1:0] en,
                                input logic hold, input int eidx,
                                input logic ev, input logic eidle);
        vec_t v;
        v.rst = rst; v.en = en; v.hold = hold;
        v.eidx = TIB'(eidx); v.evalid = ev; v.eidle = eidle;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int row);
        reset            = v.rst;
        in_thread_enable = v.en;
        in_pipeline_hold = v.hold;
        in_stall_valid   = 1'b0;
        tick();
        check($sformatf("tbl%0d_index", row), int'(out_thread_index), int'(v.eidx));
        check($sformatf("tbl%0d_valid", row), int'(out_thread_valid), int'(v.evalid));
        check($sformatf("tbl%0d_incr",  row), int'(out_increment_flag), int'(v.evalid));
        check($sformatf("tbl%0d_idle",  row), int'(out_idle), int'(v.eidle));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_stall_valid = 1'b0;
        in_pipeline_hold = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    int seq3 [15] = '{4, 5, 6, 7, 0, 1, 2, 4, 5, 6, 7, 0, 1, 2, 3};
    int seq2 [6]  = '{2, 5, 7, 2, 5, 7};

    initial begin
        reset = 1'b1;
        in_thread_enable = '1;
        in_stall_valid = 1'b0;
        in_stall_thread_index = '0;
        in_stall_cycles = '0;
        in_pipeline_hold = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = N - 1; m_idx = 0; m_valid = 0; m_idle = 0;

        // Vector table: all-enabled rotation, then a sparse mask.
        tbl[0] = mk(1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            tbl[2 + i] = mk(1'b0, 8'hFF, 1'b0, i % 8, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 8'hA4, 1'b0, 0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 8'hA4, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            tbl[14 + i] = mk(1'b0, 8'hA4, 1'b0, seq2[i], 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) apply_vec(tbl[r], r);

        // Stall thread 3 for 10 cycles while it is on the output.
        in_thread_enable = 8'hFF;
        do_reset(2);
        for (int b = 0; b < 20 && out_thread_index != 3'd3; b++) tick();
        check("t3_reach_3", int'(out_thread_index), 3);
        in_stall_valid = 1'b1;
        in_stall_thread_index = 3'd3;
        in_stall_cycles = 4'd10;
        for (int i = 0; i < 15; i++) begin
            tick();
            in_stall_valid = 1'b0;
            check($sformatf("t3_seq%0d", i), int'(out_thread_index), seq3[i]);
        end

        // Hold for 3 cycles once thread 5 has issued.
        for (int b = 0; b < 20 && out_thread_index != 3'd5; b++) tick();
        check("t4_reach_5", int'(out_thread_index), 5);
        in_pipeline_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", int'(out_thread_valid), 0);
            check("t4_hold_index", int'(out_thread_index), 5);
        end
        in_pipeline_hold = 1'b0;
        tick();
        check("t4_resume", int'(out_thread_index), 6);
        check("t4_resume_valid", int'(out_thread_valid), 1);

        // No thread enabled, then a single thread.
        in_thread_enable = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t5_idle", int'(out_idle), 1);
            check("t5_index_hold", int'(out_thread_index), 6);
        end
        in_thread_enable = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_single", int'(out_thread_index), 4);
            check("t5_single_valid", int'(out_thread_valid), 1);
            check("t5_single_idle", int'(out_idle), 0);
        end

        // Reset in the middle of a long stall on thread 1.
        in_thread_enable = 8'hFF;
        in_stall_valid = 1'b1;
        in_stall_thread_index = 3'd1;
        in_stall_cycles = 4'd15;
        tick();
        in_stall_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_index", int'(out_thread_index), 0);
        check("t6_rst_valid", int'(out_thread_valid), 0);
        check("t6_rst_idle", int'(out_idle), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_seq%0d", i), int'(out_thread_index), i);
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0)
                in_thread_enable = N'($urandom);
            else if ($urandom_range(0, 9) == 0)
                in_thread_enable = '0;
            in_stall_valid = ($urandom_range(0, 3) == 0);
            in_stall_thread_index = TIB'($urandom);
            in_stall_cycles = SCW'($urandom);
            in_pipeline_hold = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
